clock_divider_prog: RTL and testbench



---
 rtl/clock_divider_prog_if.sv | 24 ++
 rtl/clock_divider_prog.sv | 59 +++++
 tb/tb_clock_divider_prog.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/clock_divider_prog_if.sv
// clock_divider_prog_if: control and output bundle for clock_divider_prog
// master drives enable/load/div_in/high_in (and sync_in when CLKDIV_SYNC_EN is defined),
// and receives clock_out/tick/update_pending; slave is the divider side.
interface clock_divider_prog_if #(parameter int WIDTH = 28);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] high_in;
    logic             clock_out;
    logic             tick;
    logic             update_pending;
`ifdef CLKDIV_SYNC_EN
    logic             sync_in;
    modport master (output enable, load, div_in, high_in, sync_in,
                    input clock_out, tick, update_pending);
    modport slave (input enable, load, div_in, high_in, sync_in,
                   output clock_out, tick, update_pending);
`else
    modport master (output enable, load, div_in, high_in,
                    input clock_out, tick, update_pending);
    modport slave (input enable, load, div_in, high_in,
                   output clock_out, tick, update_pending);
`endif
endinterface

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: programmable clock divider with period-start tick and glitch-free updates
// Ports: clock_in (rising-edge clock), reset (async, active high), bus (slave modport):
//   enable, load, div_in, high_in in; clock_out, tick, update_pending out.
// Optional macro CLKDIV_SYNC_EN adds bus.sync_in: a rising edge restarts the period.
module clock_divider_prog #(
    parameter int WIDTH        = 28,
    parameter int DEFAULT_DIV  = 20000000,
    parameter int DEFAULT_HIGH = 10000000
) (
    input logic                  clock_in,
    input logic                  reset,
    clock_divider_prog_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);
    logic [WIDTH-1:0] cnt, active_div, active_high, pend_div, pend_high, load_div;
    logic             pending, wrap, restart, boundary;
    assign load_div = bus.div_in < MIN_DIV ? MIN_DIV : bus.div_in;
    assign wrap     = cnt == active_div - WIDTH'(1);
`ifdef CLKDIV_SYNC_EN
    logic sync_q;
    always_ff @(posedge clock_in or posedge reset)
        if (reset) sync_q <= 1'b0;
        else       sync_q <= bus.sync_in;
    assign restart = wrap || (bus.sync_in && !sync_q);
`else
    assign restart = wrap;
`endif
    // while disabled every edge is a boundary, so pending values apply at once
    assign boundary           = !bus.enable || restart;
    assign bus.update_pending = pending;
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            active_div    <= DEF_DIV;
            active_high   <= DEF_HIGH;
            pend_div      <= '0;
            pend_high     <= '0;
            pending       <= 1'b0;
            bus.clock_out <= 1'b0;
            bus.tick      <= 1'b0;
        end else begin
            cnt           <= (bus.enable && !restart) ? cnt + WIDTH'(1) : '0;
            bus.clock_out <= bus.enable && (cnt < active_high);
            bus.tick      <= bus.enable && (cnt == '0);
            if (bus.load) begin
                pend_div  <= load_div;
                pend_high <= bus.high_in;
            end
            // a load on the boundary edge bypasses the pending registers
            if (boundary && (bus.load || pending)) begin
                active_div  <= bus.load ? load_div : pend_div;
                active_high <= bus.load ? bus.high_in : pend_high;
            end
            pending <= !boundary && (bus.load || pending);
        end
    end
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: table, directed and randomized checks of clock_divider_prog
module tb_clock_divider_prog;
    typedef struct {
        bit       en;
        bit       ld;
        int       d;
        int       h;
        bit [2:0] exp;
    } vec_t;
    logic clk, rst;
    int   tests, failed;
    int   mpos, mper, mhi, mpd, mph;
    bit   mpp, eclk, etick;
    vec_t tbl [18];
    clock_divider_prog_if #(.WIDTH(28)) b ();
    clock_divider_prog #(.WIDTH(28), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)) dut (
        .clock_in(clk), .reset(rst), .bus(b));
`ifdef CLKDIV_SYNC_EN
    clock_divider_prog_if #(.WIDTH(28)) b2 ();
    clock_divider_prog #(.WIDTH(28), .DEFAULT_DIV(10), .DEFAULT_HIGH(5)) dut2 (
        .clock_in(clk), .reset(rst), .bus(b2));
`endif
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic void mreset();
        mpos = 0; mper = 10; mhi = 5; mpd = 0; mph = 0; mpp = 0;
    endfunction
    // reference: position within the period, active settings and a pending slot
    function automatic void mstep(bit en, bit ld, int d, int h);
        bit bnd;
        int np;
        bnd   = !en || (mpos == mper - 1);
        np    = en ? (mpos + 1) % mper : 0;
        eclk  = en && (mpos < mhi);
        etick = en && (mpos == 0);
        if (ld) begin
            mpd = d < 2 ? 2 : d;
            mph = h;
            mpp = 1;
        end
        if (bnd && mpp) begin
            mper = mpd;
            mhi  = mph;
            mpp  = 0;
        end
        mpos = np;
    endfunction
    task automatic chk(input string name, input bit [2:0] act, input bit [2:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: {clock_out,tick,update_pending} got %b expected %b",
                     name, $time, act, exp);
        end
    endtask
    task automatic drive(input bit en, input bit ld, input int d, input int h);
        b.enable  = en;
        b.load    = ld;
        b.div_in  = 28'(d);
        b.high_in = 28'(h);
    endtask
    task automatic cyc(input bit en, input bit ld, input int d, input int h);
        drive(en, ld, d, h);
        @(posedge clk);
        mstep(en, ld, d, h);
        #1 chk("model", {b.clock_out, b.tick, b.update_pending}, {eclk, etick, mpp});
        @(negedge clk);
    endtask
    // enabled run from a fresh period start with known settings and nothing pending
    task automatic run_const(input string name, input int n, input int per, input int hi);
        for (int k = 0; k < n; k++) begin
            drive(1, 0, 0, 0);
            @(posedge clk);
            mstep(1, 0, 0, 0);
            #1 chk(name, {b.clock_out, b.tick, b.update_pending},
                   {((k % per) < hi) ? 1'b1 : 1'b0, (k % per) == 0 ? 1'b1 : 1'b0, 1'b0});
            @(negedge clk);
        end
    endtask
    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0);
`ifdef CLKDIV_SYNC_EN
        b.sync_in   = 1'b0;
        b2.enable   = 1'b0;
        b2.load     = 1'b0;
        b2.div_in   = '0;
        b2.high_in  = '0;
        b2.sync_in  = 1'b0;
`endif
        tbl[0]  = '{1, 0, 0, 0, 3'b110};
        tbl[1]  = '{1, 0, 0, 0, 3'b100};
        tbl[2]  = '{1, 1, 6, 2, 3'b101};
        tbl[3]  = '{1, 0, 0, 0, 3'b101};
        tbl[4]  = '{1, 0, 0, 0, 3'b101};
        tbl[5]  = '{1, 0, 0, 0, 3'b001};
        tbl[6]  = '{1, 0, 0, 0, 3'b001};
        tbl[7]  = '{1, 0, 0, 0, 3'b001};
        tbl[8]  = '{1, 0, 0, 0, 3'b001};
        tbl[9]  = '{1, 0, 0, 0, 3'b000};
        tbl[10] = '{1, 0, 0, 0, 3'b110};
        tbl[11] = '{1, 0, 0, 0, 3'b100};
        tbl[12] = '{1, 0, 0, 0, 3'b000};
        tbl[13] = '{1, 0, 0, 0, 3'b000};
        tbl[14] = '{1, 0, 0, 0, 3'b000};
        tbl[15] = '{1, 0, 0, 0, 3'b000};
        tbl[16] = '{1, 0, 0, 0, 3'b110};
        tbl[17] = '{1, 0, 0, 0, 3'b100};
        repeat (2) @(negedge clk);
        #1 chk("reset_state", {b.clock_out, b.tick, b.update_pending}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        mreset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].ld, tbl[i].d, tbl[i].h);
            @(posedge clk);
            mstep(tbl[i].en, tbl[i].ld, tbl[i].d, tbl[i].h);
            #1 chk($sformatf("table_row%0d", i), {b.clock_out, b.tick, b.update_pending}, tbl[i].exp);
            @(negedge clk);
        end
        cyc(0, 1, 0, 1);
        run_const("clamp_div0", 6, 2, 1);
        cyc(0, 1, 6, 0);
        run_const("high_zero", 12, 6, 0);
        cyc(0, 1, 6, 20);
        run_const("high_over_div", 12, 6, 20);
        cyc(1, 1, 9, 4);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 1, 5, 3);
        repeat (3) cyc(0, 0, 0, 0);
        run_const("reenable", 10, 5, 3);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 15) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 12), $urandom_range(0, 14));
        cyc(0, 1, 10, 5);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 7, 3);
        #2 rst = 1'b1;
        #1 chk("async_reset", {b.clock_out, b.tick, b.update_pending}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        mreset();
        run_const("defaults_after_reset", 12, 10, 5);
`ifdef CLKDIV_SYNC_EN
        b2.enable = 1'b1;
        repeat (3) @(negedge clk);
        b.sync_in  = 1'b1;
        b2.sync_in = 1'b1;
        @(negedge clk);
        b.sync_in  = 1'b0;
        b2.sync_in = 1'b0;
        @(posedge clk);
        #1 chk("sync_tick_a", {b.tick, b2.tick, 1'b0}, 3'b110);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1 chk("sync_aligned", {b.tick, b2.tick, 1'b0},
                   {(i % 10) == 9 ? 1'b1 : 1'b0, (i % 10) == 9 ? 1'b1 : 1'b0, 1'b0});
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
